// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream in / instruction-memory write out bundle for im_loader
interface im_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output byte_in, byte_valid, byte_last,
        input  byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  byte_in, byte_valid, byte_last,
        output byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - packs a big-endian byte stream into 32-bit instruction-memory writes
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    im_loader_if.slave  bus,
    output logic [12:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [12:0] DEPTH_W = 13'(DEPTH);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [12:0] wc_q, wc_d;
    logic        error_q, error_d;
    logic        last_q, last_d;
    logic        ready_q, ready_d;
    logic        accept;

    assign accept = ready_q & bus.byte_valid;

    // State and datapath registers; reset drops any partially assembled word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            wdata_q <= 32'h0;
            addr_q  <= BASE_ADDR;
            wc_q    <= 13'd0;
            error_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            error_q <= error_d;
            last_q  <= last_d;
            ready_q <= ready_d;
        end
    end

    // Next state: byte packing, word hand-off, overflow discard and restart
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        error_d = error_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    wc_d    = 13'd0;
                    idx_d   = 2'd0;
                    error_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (wc_q == DEPTH_W) begin
                        // memory full: swallow the byte, only watch for the end of the image
                        error_d = 1'b0 | 1'b1;
                        if (bus.byte_last) state_d = S_DONE;
                    end else begin
                        case (idx_q)
                            2'd0:    wdata_d = {bus.byte_in, 24'h0};
                            2'd1:    wdata_d[23:16] = bus.byte_in;
                            2'd2:    wdata_d[15:8]  = bus.byte_in;
                            default: wdata_d[7:0]   = bus.byte_in;
                        endcase
                        if (idx_q == 2'd3 || bus.byte_last) begin
                            addr_d  = BASE_ADDR + {18'h0, wc_q[11:0], 2'b00};
                            last_d  = bus.byte_last;
                            if (bus.byte_last && idx_q != 2'd3) error_d = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end
            default: begin
                wc_d    = wc_q + 13'd1;
                idx_d   = 2'd0;
                state_d = last_q ? S_DONE : S_RECV;
            end
        endcase
        ready_d = (state_d == S_RECV);
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.byte_ready = ready_q;
        bus.im_we      = (state_q == S_WRITE);
        bus.im_addr    = addr_q;
        bus.im_wdata   = wdata_q;
        word_count     = wc_q;
        busy           = (state_q == S_RECV) || (state_q == S_WRITE);
        done           = (state_q == S_DONE);
        error          = error_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - scoreboard bench for im_loader
module tb_im_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] word_count;
    logic        busy, done, error;

    im_loader_if bus();

    im_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .word_count(word_count), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_writes = 0;
    int          c0, w0;
    logic [63:0] exp_q[$];
    logic [7:0]  stim[$];

    int          m_wc, m_idx;
    logic [31:0] m_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // every write strobe must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.im_we === 1'b1) begin
            n_writes++;
            check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check_eq("write_addr_data", {bus.im_addr, bus.im_wdata}, exp_q.pop_front());
        end
    end

    task automatic model_accept(input logic [7:0] b, input logic last);
        if (m_wc < DEPTH) begin
            if (m_idx == 0) m_word = 32'h0;
            m_word = m_word | (32'(b) << (24 - 8 * m_idx));
            if (m_idx == 3 || last) begin
                exp_q.push_back({BASE + 32'(4 * m_wc), m_word});
                m_wc++;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        m_wc = 0; m_idx = 0; m_word = 32'h0;
        c0 = cyc;
        w0 = n_writes;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t;
        bus.byte_in = b; bus.byte_valid = 1'b1; bus.byte_last = last;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check_eq("ready_timeout", 64'(t), 64'd0);
        model_accept(b, last);
        @(negedge clk);
        bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_stim(input int gap, input logic mark_last);
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], mark_last && (i == stim.size() - 1), gap);
    endtask

    task automatic finish_load(input string tag, input int exp_wc, input logic exp_err, input int exp_w);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
        check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
        check_eq({tag, "_writes"}, 64'(n_writes - w0), 64'(exp_w));
        check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check_eq({tag, "_we"}, 64'(bus.im_we), 64'd0);
        check_eq({tag, "_addr"}, 64'(bus.im_addr), 64'(BASE));
        check_eq({tag, "_wdata"}, 64'(bus.im_wdata), 64'd0);
        check_eq({tag, "_wc"}, 64'(word_count), 64'd0);
        check_eq({tag, "_flags"}, {61'h0, busy, done, error}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        bus.byte_in = 8'h0; bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // basic two-word load, continuous stream
        do_start();
        stim = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        send_stim(0, 1'b1);
        finish_load("basic", 2, 1'b0, 2);
        check_eq("basic_cycles", 64'(cyc - c0), 64'd10);

        // same image with 3-cycle gaps between bytes
        do_start();
        send_stim(3, 1'b1);
        finish_load("gaps", 2, 1'b0, 2);

        // partial final word is zero-padded and flagged
        do_start();
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_stim(0, 1'b1);
        finish_load("partial", 2, 1'b1, 2);

        // restart from DONE clears status, then start inside RECV is ignored
        do_start();
        check_eq("restart_clear", {48'h0, word_count, busy, done, error}, {48'h0, 13'd0, 3'b100});
        stim = '{8'h24, 8'h08};
        send_stim(0, 1'b0);
        pulse_start();
        stim = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        send_stim(1, 1'b1);
        finish_load("ignored_start", 2, 1'b0, 2);

        // overflow: five words into a four-word memory
        do_start();
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'(8'h40 + i));
        send_stim(0, 1'b1);
        finish_load("overflow", 4, 1'b1, 4);

        // reset mid-word, then start with byte_valid high in IDLE
        do_start();
        stim = '{8'h55, 8'h66};
        send_stim(0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        check_eq("midreset_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        bus.byte_in = 8'hEE; bus.byte_valid = 1'b1;
        do_start();
        bus.byte_valid = 1'b0;
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_stim(0, 1'b1);
        finish_load("after_reset", 1, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
